// File: rtl/stopwatch_pkg.sv
// Shared types, widths and the decimal step helper for the stopwatch counter.
// The step wraps inside 0..max_val in both directions.
package stopwatch_pkg;

  localparam int NUM_W = 14;

  typedef enum logic [1:0] {
    STOP,
    RUN,
    CLEAR
  } sw_state_t;

  function automatic logic [NUM_W-1:0] step_count(
    input logic [NUM_W-1:0] cur,
    input logic             down,
    input logic [NUM_W-1:0] max_val
  );
    logic [NUM_W-1:0] nxt;
    if (down) begin
      nxt = (cur == '0) ? max_val : cur - NUM_W'(1);
    end else begin
      nxt = (cur == max_val) ? '0 : cur + NUM_W'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/tick_gen_en.sv
// Enable-gated rate divider: one-cycle tick every TICK_CNT enabled clocks.
// Dropping en returns the count to 0, so a restart always begins a full period.
module tick_gen_en #(
  parameter int TICK_CNT = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(TICK_CNT);
  localparam logic [CW-1:0] LAST = CW'(TICK_CNT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/stopwatch_counter.sv
// Up/down decimal event counter feeding the FND number input.
// Buttons are debounced levels; only their rising edges act on the FSM.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int TICK_HZ   = 10,
  parameter int MAX_COUNT = 9999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_run_stop,
  input  logic             btn_clear,
  input  logic             btn_mode,
  output logic [NUM_W-1:0] number,
  output logic             run,
  output logic             mode_down
);

  localparam int TICK_CNT = CLK_FREQ / TICK_HZ;
  localparam logic [NUM_W-1:0] MAX_VAL = NUM_W'(MAX_COUNT);

  // FSM state is kept as a named signal so checkers can bind to it directly.
  sw_state_t        state;
  sw_state_t        state_next;
  logic [NUM_W-1:0] number_next;

  logic btn_run_stop_d;
  logic btn_clear_d;
  logic btn_mode_d;
  logic run_stop_edge;
  logic clear_edge;
  logic mode_edge;
  logic tick;
  logic tick_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_run_stop_d <= 1'b0;
      btn_clear_d    <= 1'b0;
      btn_mode_d     <= 1'b0;
    end else begin
      btn_run_stop_d <= btn_run_stop;
      btn_clear_d    <= btn_clear;
      btn_mode_d     <= btn_mode;
    end
  end

  assign run_stop_edge = btn_run_stop & ~btn_run_stop_d;
  assign clear_edge    = btn_clear & ~btn_clear_d;
  assign mode_edge     = btn_mode & ~btn_mode_d;

  assign tick_en = (state == RUN);

  tick_gen_en #(
    .TICK_CNT(TICK_CNT)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .en  (tick_en),
    .tick(tick)
  );

  // Clear outranks run/stop; CLEAR itself ignores both and always falls to STOP.
  always_comb begin
    state_next = state;
    unique case (state)
      STOP: begin
        if (clear_edge) begin
          state_next = CLEAR;
        end else if (run_stop_edge) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (clear_edge) begin
          state_next = CLEAR;
        end else if (run_stop_edge) begin
          state_next = STOP;
        end
      end
      CLEAR: begin
        state_next = STOP;
      end
      default: begin
        state_next = STOP;
      end
    endcase
  end

  // A tick coinciding with a clear edge is dropped; the zero lands one edge later.
  always_comb begin
    number_next = number;
    if (state == CLEAR) begin
      number_next = '0;
    end else if (tick_en && tick && !clear_edge) begin
      number_next = step_count(number, mode_down, MAX_VAL);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= STOP;
      run       <= 1'b0;
      number    <= '0;
      mode_down <= 1'b0;
    end else begin
      state     <= state_next;
      run       <= (state_next == RUN);
      number    <= number_next;
      mode_down <= mode_down ^ mode_edge;
    end
  end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter with TICK_CNT=10 and MAX_COUNT=15.
// A cycle-level behavioural model is compared against the outputs every cycle.
module tb_stopwatch_counter;

  localparam int TICKS = 10;
  localparam int MAXC  = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn_run_stop = 1'b0;
  logic        btn_clear = 1'b0;
  logic        btn_mode = 1'b0;
  logic [13:0] number;
  logic        run;
  logic        mode_down;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  stopwatch_counter #(
    .CLK_FREQ (1000),
    .TICK_HZ  (100),
    .MAX_COUNT(MAXC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_run_stop(btn_run_stop),
    .btn_clear   (btn_clear),
    .btn_mode    (btn_mode),
    .number      (number),
    .run         (run),
    .mode_down   (mode_down)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct {
    int num;
    bit running;
    bit down;
    bit clearing;
    int elapsed;
    bit rs_p;
    bit cl_p;
    bit md_p;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.num = 0; r.running = 0; r.down = 0; r.clearing = 0;
    r.elapsed = 0; r.rs_p = 0; r.cl_p = 0; r.md_p = 0;
    return r;
  endfunction

  function automatic model_t model_next(model_t c, bit rs, bit cl, bit md);
    model_t n;
    bit rs_e, cl_e, md_e, stepping;
    n = c;
    rs_e = rs && !c.rs_p;
    cl_e = cl && !c.cl_p;
    md_e = md && !c.md_p;
    n.rs_p = rs; n.cl_p = cl; n.md_p = md;
    if (md_e) n.down = !c.down;
    if (c.clearing) begin
      n.num = 0; n.clearing = 0; n.running = 0; n.elapsed = 0;
    end else begin
      stepping = c.running && (c.elapsed == TICKS - 1);
      if (c.running) n.elapsed = (c.elapsed + 1) % TICKS;
      if (cl_e) begin
        n.clearing = 1; n.running = 0; n.elapsed = 0;
      end else begin
        if (stepping)
          n.num = c.down ? (c.num + MAXC) % (MAXC + 1) : (c.num + 1) % (MAXC + 1);
        if (rs_e) begin
          n.running = !c.running; n.elapsed = 0;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m <= model_reset();
    else      m <= model_next(m, btn_run_stop, btn_clear, btn_mode);
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_number", int'(number), m.num);
      check("cmp_run", int'(run), int'(m.running));
      check("cmp_mode_down", int'(mode_down), int'(m.down));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press(input bit rs, input bit cl, input bit md);
    btn_run_stop = rs;
    btn_clear    = cl;
    btn_mode     = md;
    cycles(1);
    btn_run_stop = 1'b0;
    btn_clear    = 1'b0;
    btn_mode     = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    cycles(3);
    rst = 1'b1;
    cmp_en = 1'b1;
    check("reset_number", int'(number), 0);
    check("reset_run", int'(run), 0);
    check("reset_mode", int'(mode_down), 0);

    // Reset mid-run at number 7 with mode_down set
    press(1, 0, 0);
    cycles(70);
    check("t1_count7", int'(number), 7);
    press(0, 0, 1);
    check("t1_mode_set", int'(mode_down), 1);
    #1 rst = 1'b0;
    #1;
    check("t1_async_number", int'(number), 0);
    check("t1_async_run", int'(run), 0);
    check("t1_async_mode", int'(mode_down), 0);
    cycles(2);
    rst = 1'b1;
    cycles(50);
    check("t1_hold_number", int'(number), 0);
    check("t1_hold_run", int'(run), 0);

    // Count up, stop, hold, restart
    press(1, 0, 0);
    check("t2_run", int'(run), 1);
    cycles(50);
    check("t2_count5", int'(number), 5);
    press(1, 0, 0);
    check("t2_stopped", int'(run), 0);
    cycles(100);
    check("t2_hold5", int'(number), 5);
    press(1, 0, 0);
    cycles(9);
    check("t2_before_step", int'(number), 5);
    cycles(1);
    check("t2_restart6", int'(number), 6);

    // Up wrap
    cycles(80);
    check("t3_14", int'(number), 14);
    cycles(10);
    check("t3_15", int'(number), 15);
    cycles(10);
    check("t3_wrap0", int'(number), 0);
    cycles(10);
    check("t3_1", int'(number), 1);

    // Down wrap
    press(0, 0, 1);
    check("t4_mode_down", int'(mode_down), 1);
    cycles(9);
    check("t4_0", int'(number), 0);
    cycles(10);
    check("t4_wrap15", int'(number), 15);
    cycles(10);
    check("t4_14", int'(number), 14);

    // Clear while running at 9
    cycles(50);
    check("t5_9", int'(number), 9);
    press(0, 1, 0);
    check("t5_clear_run", int'(run), 0);
    check("t5_clear_hold", int'(number), 9);
    cycles(1);
    check("t5_cleared", int'(number), 0);
    press(0, 0, 1);
    check("t5_mode_up", int'(mode_down), 0);
    press(1, 0, 0);
    cycles(9);
    check("t5_before_step", int'(number), 0);
    cycles(1);
    check("t5_first_step", int'(number), 1);

    // Simultaneous edges in STOP, then held buttons
    press(1, 0, 0);
    check("t6_stopped", int'(run), 0);
    btn_run_stop = 1'b1;
    btn_clear    = 1'b1;
    btn_mode     = 1'b1;
    cycles(1);
    check("t6_run", int'(run), 0);
    check("t6_mode_toggled", int'(mode_down), 1);
    cycles(1);
    check("t6_number0", int'(number), 0);
    cycles(20);
    check("t6_held_number", int'(number), 0);
    check("t6_held_run", int'(run), 0);
    check("t6_held_mode", int'(mode_down), 1);
    btn_run_stop = 1'b0;
    btn_clear    = 1'b0;
    btn_mode     = 1'b0;
    cycles(2);

    // Tick coinciding with mode, run_stop and clear edges
    press(0, 0, 1);
    check("t7_mode_up", int'(mode_down), 0);
    press(1, 0, 0);
    cycles(9);
    press(0, 0, 1);
    check("t7_tick_mode_old_dir", int'(number), 1);
    check("t7_tick_mode_new", int'(mode_down), 1);
    cycles(10);
    check("t7_new_dir_step", int'(number), 0);
    cycles(9);
    press(1, 0, 0);
    check("t7_tick_stop_step", int'(number), 15);
    check("t7_tick_stop_run", int'(run), 0);
    press(1, 0, 0);
    cycles(9);
    press(0, 1, 0);
    check("t7_tick_clear_nostep", int'(number), 15);
    check("t7_tick_clear_run", int'(run), 0);
    cycles(1);
    check("t7_tick_clear_zero", int'(number), 0);

    cycles(5);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
